ni_packetizer: RTL and testbench
================================

Name: ni_packetizer

Overview:
- Downstream neighbour of the NI write FIFO. Pops 64-bit {data[63:32], addr[31:0]} entries from the FIFO.
- Converts each entry into a 2-flit NoC packet: a HEAD flit carrying routing information and address, then a TAIL flit carrying data.
- Injects flits into the local router port under credit-based flow control.
- Sits between the NI's gp_fifo read side and the router's local input buffer.

Parameters:
- SRC_ID, 0: this node's ID, placed in every HEAD flit.
- NODE_ID_W, 4: node ID width.
- DEST_LSB, 24: LSB of the destination-node field in addr. dest = addr[DEST_LSB +: NODE_ID_W]. Legal only if 2*NODE_ID_W + DEST_LSB == 32.
- CREDITS, 4: depth of the router local input buffer. Also the credit counter reset value.
- FLIT_W, 34: flit width (2-bit type + 32-bit payload).

Ports:
- aclk, input, 1: clock.
- arestn, input, 1: asynchronous active-low reset.
- fifo_empty, input, 1: NI FIFO empty.
- fifo_rd_en, output, 1: NI FIFO pop strobe.
- fifo_rd_data, input, 64: FIFO output, valid one cycle after fifo_rd_en.
- flit_valid, output, 1: flit_out valid this cycle; one flit per asserted cycle.
- flit_out, output, FLIT_W: {type[1:0], payload[31:0]}.
- credit_in, input, 1: one-cycle pulse; the router freed one buffer slot.
- busy, output, 1: high in any state other than IDLE.
- credit_err, output, 1: sticky flag; a credit was returned while the counter was already at CREDITS.
- pkt_count, output, 16: packets sent (see Optional Feature).

Behaviour:
- Reset (arestn low, asynchronous): state=IDLE, credits=CREDITS, entry register=0. All outputs are 0: fifo_rd_en, flit_valid, flit_out, busy, credit_err, pkt_count.
- All outputs are registered.
- FSM states: IDLE, FETCH, HEAD, TAIL.
- IDLE:
  - If !fifo_empty: assert fifo_rd_en for exactly one cycle and go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: capture fifo_rd_data into the entry register; go to HEAD.
- HEAD:
  - If credits>0: flit_valid=1, flit_out={2'b10, dest, SRC_ID[NODE_ID_W-1:0], addr[DEST_LSB-1:0]}; decrement credits; go to TAIL.
  - Else stall in HEAD with flit_valid=0.
- TAIL:
  - If credits>0: flit_valid=1, flit_out={2'b01, data[31:0]}; decrement credits; increment pkt_count; go to IDLE.
  - Else stall in TAIL.
- Latency: FIFO non-empty to HEAD flit on the wire is 3 cycles with credits available. Steady-state throughput is one packet per 4 cycles.
- flit_out holds its last value when flit_valid=0; consumers ignore it.
- Credit arithmetic:
  - A send and credit_in in the same cycle leave the count unchanged.
  - credit_in with no send while credits==CREDITS: the counter stays at CREDITS and credit_err is set.
  - credits never underflows, because a send requires credits>0.
- The packetizer never pops while a packet is in flight. Flits of different packets are never interleaved.
- fifo_empty is ignored outside IDLE.
- Reset mid-packet: the in-flight packet is abandoned and credits reload to CREDITS. The router must be reset in the same domain.
- credit_err clears only on reset.

Optional Feature:
- Macro NI_PKT_STATS_EN.
- Defined: pkt_count is a 16-bit counter, incremented on each TAIL send, saturating at 16'hFFFF.
- Undefined: no counter logic is built and pkt_count is tied to 0.

Decomposition:
- Shared package ni_pkg holds:
  - flit type constants: FLIT_IDLE=2'b00, FLIT_TAIL=2'b01, FLIT_HEAD=2'b10, FLIT_HT=2'b11 (reserved for single-flit packets);
  - FSM state encoding;
  - the FLIT_W definition.
- One sub-module, ni_credit_counter: up/down counter with parameter CREDITS.
  - Ports: aclk, arestn, consume, credit_in, has_credit, credit_err.

Test Plan:
- Single entry, default parameters, SRC_ID=3: push {data=32'hDEADBEEF, addr=32'h05123456}.
  - Expect fifo_rd_en for 1 cycle, then HEAD flit_out=34'h2_53123456, then next cycle TAIL flit_out=34'h1_DEADBEEF. pkt_count=1.
- Credit starvation: CREDITS=2, 2 entries queued, no credit_in.
  - Expect 1 packet (2 flits) sent, then a stall in HEAD with busy=1.
  - Pulse credit_in once: HEAD is sent, then a stall in TAIL.
  - Pulse again: TAIL is sent.
- Simultaneous credit and send: credits=1, credit_in pulsed in the same cycle as the HEAD send.
  - Expect credits to stay 1 and TAIL to be sent the next cycle.
- Credit overflow: at reset (credits=4), pulse credit_in.
  - Expect credit_err=1 and sticky, and credits to stay 4.
- Reset mid-packet: assert arestn=0 while in TAIL.
  - Expect flit_valid=0, busy=0 and credits=4 immediately, without waiting for a clock edge.
  - After release, the next FIFO entry is packetized normally.
- Back-to-back: 3 entries queued, credits unlimited (credit_in returned every send).
  - Expect 6 flits in HEAD/TAIL order with 2 idle cycles between packets, and pkt_count=3.
  - With NI_PKT_STATS_EN undefined, pkt_count stays 0.

Source files
------------

// File: rtl/ni_pkg.sv
// ni_pkg: shared definitions for the NI packetizer.
//   FLIT_W / PAYLOAD_W : flit geometry ({type[1:0], payload[31:0]})
//   FLIT_*             : flit type codes
//   pkt_state_t        : packetizer FSM state encoding
//   sat_inc16          : saturating 16-bit increment used by the packet counter
package ni_pkg;

  localparam int FLIT_W    = 34;
  localparam int PAYLOAD_W = 32;

  localparam logic [1:0] FLIT_IDLE = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;
  localparam logic [1:0] FLIT_HEAD = 2'b10;
  localparam logic [1:0] FLIT_HT   = 2'b11;  // reserved: single-flit packets

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HEAD  = 2'd2,
    ST_TAIL  = 2'd3
  } pkt_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ni_packetizer_if.sv
// ni_packetizer_if: FIFO-read and router-injection signals of the packetizer.
//   fifo_empty   : NI FIFO empty
//   fifo_rd_en   : pop strobe
//   fifo_rd_data : {data[63:32], addr[31:0]} at the FIFO head
//   flit_valid   : one flit on flit_out this cycle
//   flit_out     : {type[1:0], payload[31:0]}
//   credit_in    : one-cycle pulse, router freed a buffer slot
// master = packetizer side, slave = FIFO/router side.
interface ni_packetizer_if;
  import ni_pkg::*;

  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [63:0]       fifo_rd_data;
  logic              flit_valid;
  logic [FLIT_W-1:0] flit_out;
  logic              credit_in;

  modport master (
    input  fifo_empty, fifo_rd_data, credit_in,
    output fifo_rd_en, flit_valid, flit_out
  );

  modport slave (
    output fifo_empty, fifo_rd_data, credit_in,
    input  fifo_rd_en, flit_valid, flit_out
  );

endinterface

// File: rtl/ni_credit_counter.sv
// ni_credit_counter: tracks free slots in the router local input buffer.
//   aclk, arestn : clock, asynchronous active-low reset (count reloads to CREDITS)
//   consume      : a flit is sent this cycle (only asserted while has_credit)
//   credit_in    : router returned one slot
//   has_credit   : at least one slot free
//   credit_err   : sticky, a credit arrived while the counter was already full
module ni_credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic aclk,
  input  logic arestn,
  input  logic consume,
  input  logic credit_in,
  output logic has_credit,
  output logic credit_err
);

  localparam int              CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(CREDITS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      count      <= FULL;
      credit_err <= 1'b0;
    end else if (consume && !credit_in) begin
      count <= count - ONE;
    end else if (credit_in && !consume) begin
      // An extra credit would overflow the model of the router buffer:
      // flag it and keep the count pinned at the buffer depth.
      if (count == FULL) credit_err <= 1'b1;
      else               count      <= count + ONE;
    end
  end

  assign has_credit = (count != '0);

endmodule

// File: rtl/ni_packetizer.sv
// ni_packetizer: pops {data, addr} entries from the NI write FIFO and injects
// each one as a HEAD + TAIL flit pair into the local router port under
// credit-based flow control.
//   aclk, arestn : clock, asynchronous active-low reset
//   bus          : ni_packetizer_if.master (FIFO read side + flit/credit side)
//   busy         : FSM is not in IDLE
//   credit_err   : sticky credit overflow flag
//   pkt_count    : packets sent (saturating); only built with NI_PKT_STATS_EN,
//                  otherwise tied to 0
// The FIFO is show-ahead: fifo_rd_data holds the head entry while fifo_rd_en
// is high, and FETCH captures it on the same edge that performs the pop.
// Parameters must satisfy 2*NODE_ID_W + DEST_LSB == 32.
module ni_packetizer
  import ni_pkg::*;
#(
  parameter int SRC_ID    = 0,
  parameter int NODE_ID_W = 4,
  parameter int DEST_LSB  = 24,
  parameter int CREDITS   = 4,
  parameter int FLIT_W    = ni_pkg::FLIT_W
) (
  input  logic                   aclk,
  input  logic                   arestn,
  ni_packetizer_if.master        bus,
  output logic                   busy,
  output logic                   credit_err,
  output logic [15:0]            pkt_count
);

  localparam logic [NODE_ID_W-1:0] SRC = NODE_ID_W'(SRC_ID);

  pkt_state_t        state;
  logic [63:0]       entry;
  logic              has_credit;
  logic              consume;
  logic [FLIT_W-1:0] head_flit;
  logic [FLIT_W-1:0] tail_flit;
  logic              unused_addr_hi;

  // HEAD: {type, dest, src, addr low bits}; TAIL: {type, data}
  assign head_flit = {FLIT_HEAD, entry[DEST_LSB +: NODE_ID_W], SRC, entry[DEST_LSB-1:0]};
  assign tail_flit = {FLIT_TAIL, entry[63:32]};
  assign unused_addr_hi = ^entry[31:DEST_LSB+NODE_ID_W];

  assign consume = has_credit && ((state == ST_HEAD) || (state == ST_TAIL));

  ni_credit_counter #(.CREDITS(CREDITS)) u_credit (
    .aclk       (aclk),
    .arestn     (arestn),
    .consume    (consume),
    .credit_in  (bus.credit_in),
    .has_credit (has_credit),
    .credit_err (credit_err)
  );

  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      state          <= ST_IDLE;
      entry          <= '0;
      bus.fifo_rd_en <= 1'b0;
      bus.flit_valid <= 1'b0;
      bus.flit_out   <= '0;
      busy           <= 1'b0;
    end else begin
      bus.fifo_rd_en <= 1'b0;
      bus.flit_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.fifo_empty) begin
            bus.fifo_rd_en <= 1'b1;
            busy           <= 1'b1;
            state          <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          entry <= bus.fifo_rd_data;
          state <= ST_HEAD;
        end
        ST_HEAD: begin
          if (has_credit) begin
            bus.flit_valid <= 1'b1;
            bus.flit_out   <= head_flit;
            state          <= ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (has_credit) begin
            bus.flit_valid <= 1'b1;
            bus.flit_out   <= tail_flit;
            busy           <= 1'b0;
            state          <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef NI_PKT_STATS_EN
  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn)                            pkt_count <= '0;
    else if (has_credit && state == ST_TAIL) pkt_count <= sat_inc16(pkt_count);
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
// Testbench for ni_packetizer: two instances (CREDITS=4 and CREDITS=2,
// both SRC_ID=3) fed by show-ahead FIFO models; expected flits are queued
// at push time and checked by monitors as the DUTs emit them.
module tb_ni_packetizer;
  import ni_pkg::*;

  logic aclk = 1'b0;
  logic rst_a, rst_b;
  always #5 aclk = ~aclk;

  ni_packetizer_if ifa();
  ni_packetizer_if ifb();

  logic        busy_a, err_a, busy_b, err_b;
  logic [15:0] cnt_a, cnt_b;

  ni_packetizer #(.SRC_ID(3), .CREDITS(4)) dut_a (
    .aclk(aclk), .arestn(rst_a), .bus(ifa),
    .busy(busy_a), .credit_err(err_a), .pkt_count(cnt_a));

  ni_packetizer #(.SRC_ID(3), .CREDITS(2)) dut_b (
    .aclk(aclk), .arestn(rst_b), .bus(ifb),
    .busy(busy_b), .credit_err(err_b), .pkt_count(cnt_b));

`ifdef NI_PKT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  logic [63:0] fq_a[$], fq_b[$];
  logic [33:0] exp_a[$], exp_b[$];
  bit auto_a = 1'b0, man_a = 1'b0, man_b = 1'b0;
  bit prev_rd_a = 1'b0, prev_rd_b = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic upd_a();
    ifa.fifo_empty   = (fq_a.size() == 0);
    ifa.fifo_rd_data = (fq_a.size() != 0) ? fq_a[0] : 64'd0;
  endtask

  task automatic upd_b();
    ifb.fifo_empty   = (fq_b.size() == 0);
    ifb.fifo_rd_data = (fq_b.size() != 0) ? fq_b[0] : 64'd0;
  endtask

  task automatic push_a(input logic [31:0] data, input logic [31:0] addr,
                        input logic [33:0] eh, input logic [33:0] et);
    fq_a.push_back({data, addr});
    exp_a.push_back(eh);
    exp_a.push_back(et);
    upd_a();
  endtask

  task automatic push_b(input logic [31:0] data, input logic [31:0] addr,
                        input logic [33:0] eh, input logic [33:0] et);
    fq_b.push_back({data, addr});
    exp_b.push_back(eh);
    exp_b.push_back(et);
    upd_b();
  endtask

  // FIFO pop: the entry leaves the head just after the edge that samples rd_en
  always @(negedge aclk) if (ifa.fifo_rd_en) begin
    @(posedge aclk); #1;
    if (fq_a.size() != 0) void'(fq_a.pop_front());
    upd_a();
  end

  always @(negedge aclk) if (ifb.fifo_rd_en) begin
    @(posedge aclk); #1;
    if (fq_b.size() != 0) void'(fq_b.pop_front());
    upd_b();
  end

  // Monitors: compare every emitted flit, drive credit returns
  always @(negedge aclk) begin
    if (ifa.flit_valid) begin
      if (exp_a.size() == 0) begin
        total++; bad++;
        $display("FAIL flit_a: got %0h expected no flit", ifa.flit_out);
      end else begin
        logic [33:0] e;
        e = exp_a.pop_front();
        check("flit_a", 64'(ifa.flit_out), 64'(e));
      end
    end
    if (ifa.fifo_rd_en) check("rd_en_a_single", 64'(prev_rd_a), 64'd0);
    prev_rd_a     = ifa.fifo_rd_en;
    ifa.credit_in = (auto_a && ifa.flit_valid) || man_a;
  end

  always @(negedge aclk) begin
    if (ifb.flit_valid) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL flit_b: got %0h expected no flit", ifb.flit_out);
      end else begin
        logic [33:0] e;
        e = exp_b.pop_front();
        check("flit_b", 64'(ifb.flit_out), 64'(e));
      end
    end
    if (ifb.fifo_rd_en) check("rd_en_b_single", 64'(prev_rd_b), 64'd0);
    prev_rd_b     = ifb.fifo_rd_en;
    ifb.credit_in = man_b;
  end

  // Credit pulses: aligned so credit_in covers exactly one rising edge
  task automatic pulse_a();
    @(posedge aclk); #1 man_a = 1'b1;
    @(posedge aclk); #1 man_a = 1'b0;
  endtask

  task automatic pulse_b();
    @(posedge aclk); #1 man_b = 1'b1;
    @(posedge aclk); #1 man_b = 1'b0;
  endtask

  task automatic drain_a(input string name, input int lim);
    int n = 0;
    while (exp_a.size() != 0 && n < lim) begin @(negedge aclk); n++; end
    #1 check(name, 64'(exp_a.size()), 64'd0);
  endtask

  task automatic drain_b(input string name, input int lim);
    int n = 0;
    while (exp_b.size() != 0 && n < lim) begin @(negedge aclk); n++; end
    #1 check(name, 64'(exp_b.size()), 64'd0);
  endtask

  task automatic reset_a();
    @(posedge aclk); #1 rst_a = 1'b0;
    @(posedge aclk); #1 rst_a = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;
    int n;
    rst_a = 1'b0; rst_b = 1'b0;
    upd_a(); upd_b();
    #1;
    check("rst_rd_en",   64'(ifa.fifo_rd_en), 64'd0);
    check("rst_valid",   64'(ifa.flit_valid), 64'd0);
    check("rst_flit",    64'(ifa.flit_out),   64'd0);
    check("rst_busy",    64'(busy_a),         64'd0);
    check("rst_err",     64'(err_a),          64'd0);
    check("rst_pkt",     64'(cnt_a),          64'd0);
    check("rst_busy_b",  64'(busy_b),         64'd0);
    repeat (2) @(posedge aclk);
    #1 rst_a = 1'b1; rst_b = 1'b1;

    // Single entry, credits returned for every flit
    auto_a = 1'b1;
    push_a(32'hDEADBEEF, 32'h05123456, 34'h2_53123456, 34'h1_DEADBEEF);
    n = 0;
    while (n < 20) begin
      @(negedge aclk);
      if (ifa.flit_valid) break;
      n++;
    end
    check("head_latency", 64'(n), 64'd3);
    drain_a("single_drain", 20);
    check("single_pkt", 64'(cnt_a), STATS ? 64'd1 : 64'd0);
    check("single_err", 64'(err_a), 64'd0);

    // Reset while the TAIL is pending
    @(posedge aclk); #1;
    push_a(32'h12345678, 32'h0A0000FF, 34'h2_A30000FF, 34'h1_12345678);
    n = 0;
    while (!ifa.flit_valid && n < 20) begin @(negedge aclk); n++; end
    #2 rst_a = 1'b0;
    #1;
    check("midrst_valid", 64'(ifa.flit_valid), 64'd0);
    check("midrst_busy",  64'(busy_a),         64'd0);
    check("midrst_rd_en", 64'(ifa.fifo_rd_en), 64'd0);
    exp_a.delete();
    auto_a = 1'b0;
    repeat (2) @(posedge aclk);
    #1 rst_a = 1'b1;
    // Two packets with no credit returns need all four credits back
    push_a(32'hCAFE0001, 32'h03000010, 34'h2_33000010, 34'h1_CAFE0001);
    push_a(32'h0000BEEF, 32'h0F000001, 34'h2_F3000001, 34'h1_0000BEEF);
    drain_a("post_rst_drain", 40);
    check("post_rst_pkt", 64'(cnt_a), STATS ? 64'd2 : 64'd0);

    // Credit overflow at full count
    reset_a();
    pulse_a();
    repeat (2) @(posedge aclk);
    check("ovf_err", 64'(err_a), 64'd1);
    repeat (5) @(posedge aclk);
    check("ovf_err_sticky", 64'(err_a), 64'd1);
    push_a(32'h00000001, 32'h01000000, 34'h2_13000000, 34'h1_00000001);
    push_a(32'hFFFFFFFF, 32'hFFFFFFFF, 34'h2_F3FFFFFF, 34'h1_FFFFFFFF);
    push_a(32'hA5A5A5A5, 32'h02ABCDEF, 34'h2_23ABCDEF, 34'h1_A5A5A5A5);
    repeat (30) @(posedge aclk);
    #1;
    check("ovf_only4_sent", 64'(exp_a.size()), 64'd2);
    check("ovf_stall_busy", 64'(busy_a),       64'd1);
    pulse_a();
    repeat (4) @(posedge aclk);
    pulse_a();
    drain_a("ovf_drain", 20);
    check("ovf_err_still", 64'(err_a), 64'd1);

    // Back-to-back with credits returned every send
    reset_a();
    auto_a = 1'b1;
    push_a(32'h00000001, 32'h01000000, 34'h2_13000000, 34'h1_00000001);
    push_a(32'hFFFFFFFF, 32'hFFFFFFFF, 34'h2_F3FFFFFF, 34'h1_FFFFFFFF);
    push_a(32'hA5A5A5A5, 32'h02ABCDEF, 34'h2_23ABCDEF, 34'h1_A5A5A5A5);
    for (int i = 0; i < 16; i++) begin
      @(negedge aclk);
      pat[i] = ifa.flit_valid;
    end
    check("b2b_pattern", 64'(pat), 64'h1998);
    drain_a("b2b_drain", 20);
    check("b2b_pkt", 64'(cnt_a), STATS ? 64'd3 : 64'd0);

    // Starvation on the CREDITS=2 instance
    @(posedge aclk); #1;
    push_b(32'h11111111, 32'h04000002, 34'h2_43000002, 34'h1_11111111);
    push_b(32'h22222222, 32'h06000003, 34'h2_63000003, 34'h1_22222222);
    repeat (15) @(posedge aclk);
    #1;
    check("starve_left2", 64'(exp_b.size()), 64'd2);
    check("starve_busy",  64'(busy_b),       64'd1);
    pulse_b();
    repeat (5) @(posedge aclk);
    #1;
    check("starve_left1", 64'(exp_b.size()), 64'd1);
    check("starve_busy2", 64'(busy_b),       64'd1);
    pulse_b();
    repeat (5) @(posedge aclk);
    #1;
    check("starve_left0", 64'(exp_b.size()), 64'd0);
    check("starve_idle",  64'(busy_b),       64'd0);

    // One credit, returned on the same edge the HEAD is sent
    pulse_b();
    @(posedge aclk); #1;
    push_b(32'h33333333, 32'h07000004, 34'h2_73000004, 34'h1_33333333);
    @(posedge aclk);
    @(posedge aclk); #1 man_b = 1'b1;
    @(posedge aclk); #1 man_b = 1'b0;
    @(negedge aclk);
    check("simul_head_valid", 64'(ifb.flit_valid), 64'd1);
    @(negedge aclk);
    check("simul_tail_valid", 64'(ifb.flit_valid), 64'd1);
    drain_b("simul_drain", 10);
    check("b_pkt",  64'(cnt_b), STATS ? 64'd3 : 64'd0);
    check("b_err",  64'(err_b), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
